cache_bus_arbiter: RTL and testbench
====================================

Name: cache_bus_arbiter

Overview:
- Shares the single cache refill bus between two requesters: port 0 = instruction fetch (icache refill / uncached fetch) and port 1 = data cache (refill, writeback, uncached load/store).
- Serialises whole burst transactions and holds the grant until the transaction completes.
- Drives a per-port busy indication so each requester knows the bus is held by the other.
- Sits between the two cache controllers and the core's external memory bridge.

Parameters:
- LEN_W, 8, width of burst length field; len = beats-1.
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 1 always wins a tie.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- m_req_valid_i  in  [1:0]  per-port transaction request
- m_req_ready_o  out  [1:0]  per-port request accepted (address handshake done)
- m_req_addr_i  in  [1:0][31:0]  per-port start address
- m_req_write_i  in  [1:0]  1 = write burst
- m_req_len_i  in  [1:0][LEN_W-1:0]  beats-1
- m_wdata_i  in  [1:0][31:0]  write data
- m_wvalid_i  in  [1:0]  write beat valid
- m_wready_o  out  [1:0]  write beat accepted
- m_rdata_o  out  32  read data, broadcast to both ports
- m_rvalid_o  out  [1:0]  read beat valid, granted port only
- m_rlast_o  out  1  last read beat
- m_wdone_o  out  [1:0]  one-cycle write-response pulse
- m_busy_o  out  [1:0]  bus held by the other port
- bus_req_valid_o  out  1  downstream request valid
- bus_req_ready_i  in  1  downstream request accepted
- bus_addr_o  out  32  downstream address
- bus_write_o  out  1  downstream write flag
- bus_len_o  out  LEN_W  downstream beats-1
- bus_wdata_o  out  32  downstream write data
- bus_wvalid_o  out  1  downstream write beat valid
- bus_wready_i  in  1  downstream write beat accepted
- bus_wlast_o  out  1  downstream last write beat
- bus_rdata_i  in  32  downstream read data
- bus_rvalid_i  in  1  downstream read beat valid
- bus_rlast_i  in  1  downstream last read beat
- bus_bvalid_i  in  1  downstream write response

Behaviour:
- FSM states: IDLE, ADDR, RDATA, WDATA, WRESP. Registered grant index `gnt` (1 bit) and beat counter `cnt` (LEN_W bits).
- Reset:
  - state = IDLE, `cnt` = 0.
  - Round-robin pointer `last` = 1, so port 0 wins the first tie.
  - All outputs 0, except data/addr buses, which are don't-care but driven from the granted port.
- IDLE arbitration:
  - If any m_req_valid_i is set: single requester wins.
  - On a tie, FIXED_PRIO=1 picks port 1; FIXED_PRIO=0 picks the port != `last`.
  - Next cycle: state = ADDR, `gnt` registered, `last` <= winner.
  - No request: stay IDLE.
- ADDR:
  - bus_req_valid_o = 1.
  - bus_addr_o / bus_write_o / bus_len_o pass through combinationally from port `gnt`.
  - m_req_ready_o[gnt] = bus_req_ready_i.
  - On handshake: `cnt` <= 0; go to WDATA if write, else RDATA.
  - Requester must hold addr/len/write stable while valid and not ready.
  - Handshake latency: request seen in cycle t → bus_req_valid_o high at t+1 at the earliest.
- RDATA:
  - m_rdata_o = bus_rdata_i.
  - m_rvalid_o[gnt] = bus_rvalid_i.
  - m_rlast_o = bus_rvalid_i & bus_rlast_i.
  - On the rlast beat: go to IDLE.
  - No backpressure on read beats; requesters must sink one beat per cycle.
- WDATA:
  - bus_wvalid_o = m_wvalid_i[gnt]; bus_wdata_o = m_wdata_i[gnt].
  - m_wready_o[gnt] = bus_wready_i.
  - bus_wlast_o = (cnt == len captured at ADDR handshake).
  - On each accepted beat: `cnt`++.
  - On accepted last beat: go to WRESP.
- WRESP: on bus_bvalid_i, m_wdone_o[gnt] pulses 1 cycle and state goes to IDLE.
- Non-granted port: m_req_ready_o / m_wready_o / m_rvalid_o / m_wdone_o are held 0.
- m_busy_o[p] = (state != IDLE) & (gnt != p).
- Boundary behaviour:
  - len = 0 means single beat: wlast high on the first beat; rlast is expected on the first beat.
  - len = 2^LEN_W-1 means a maximal burst; `cnt` never wraps before wlast.
  - A bus_rvalid_i, bus_bvalid_i or bus_wready_i that arrives in a state where it is not expected is ignored.
  - A requester dropping m_req_valid_i during ADDR is illegal; it is not supported and need not be handled.
  - A requester flush mid-burst does not abort; the transaction completes on the bus.
  - Synchronous reset mid-transaction forces IDLE immediately and all outputs to 0; downstream is reset together.
- Throughput: back-to-back transactions spend ≥1 IDLE cycle between completion and the next ADDR.

Test Plan:
- Single read, port 0, addr 0x1C000000, len 3, bus ready immediately:
  - bus_req_valid_o at cycle +1.
  - 4 m_rvalid_o[0] beats passed through; m_rlast_o on the 4th.
  - m_busy_o = 2'b10 during the transaction; returns to IDLE.
- Simultaneous requests, FIXED_PRIO=0, both ports len 0 read, repeated 4 times:
  - Grants alternate 0,1,0,1.
  - With FIXED_PRIO=1: port 1 is granted every tie.
- Write burst, port 1, len 2, data 0xA,0xB,0xC; bus_wready_i toggling 1,0,1,0,1:
  - Exactly 3 beats accepted; bus_wlast_o only with 0xC.
  - WRESP waits; bus_bvalid_i 5 cycles later → m_wdone_o[1] pulse.
- Port 1 requests while port 0 is mid-read-burst:
  - m_busy_o[1] = 1; m_req_ready_o[1] = 0 until port 0's rlast.
  - Port 1 is granted in the following arbitration cycle.
- Reset asserted at the 2nd beat of a len 7 read:
  - Next cycle state = IDLE; all outputs 0.
  - A new port 0 request is granted normally.
- len 0 write with bus_req_ready_i delayed 3 cycles:
  - m_req_ready_o[0] pulses with the handshake.
  - The single beat carries bus_wlast_o = 1.

Source files
------------

// File: rtl/cache_bus_arbiter_if.sv
// Requester-side and downstream-side signals of the shared cache refill bus.
// The arbiter connects through the slave modport; the environment through master.
interface cache_bus_arbiter_if #(parameter int LEN_W = 8);
  logic [1:0]            m_req_valid_i;
  logic [1:0]            m_req_ready_o;
  logic [1:0][31:0]      m_req_addr_i;
  logic [1:0]            m_req_write_i;
  logic [1:0][LEN_W-1:0] m_req_len_i;
  logic [1:0][31:0]      m_wdata_i;
  logic [1:0]            m_wvalid_i;
  logic [1:0]            m_wready_o;
  logic [31:0]           m_rdata_o;
  logic [1:0]            m_rvalid_o;
  logic                  m_rlast_o;
  logic [1:0]            m_wdone_o;
  logic [1:0]            m_busy_o;
  logic                  bus_req_valid_o;
  logic                  bus_req_ready_i;
  logic [31:0]           bus_addr_o;
  logic                  bus_write_o;
  logic [LEN_W-1:0]      bus_len_o;
  logic [31:0]           bus_wdata_o;
  logic                  bus_wvalid_o;
  logic                  bus_wready_i;
  logic                  bus_wlast_o;
  logic [31:0]           bus_rdata_i;
  logic                  bus_rvalid_i;
  logic                  bus_rlast_i;
  logic                  bus_bvalid_i;

  modport slave (
    input  m_req_valid_i, m_req_addr_i, m_req_write_i, m_req_len_i,
           m_wdata_i, m_wvalid_i,
           bus_req_ready_i, bus_wready_i, bus_rdata_i, bus_rvalid_i,
           bus_rlast_i, bus_bvalid_i,
    output m_req_ready_o, m_wready_o, m_rdata_o, m_rvalid_o, m_rlast_o,
           m_wdone_o, m_busy_o,
           bus_req_valid_o, bus_addr_o, bus_write_o, bus_len_o,
           bus_wdata_o, bus_wvalid_o, bus_wlast_o
  );

  modport master (
    output m_req_valid_i, m_req_addr_i, m_req_write_i, m_req_len_i,
           m_wdata_i, m_wvalid_i,
           bus_req_ready_i, bus_wready_i, bus_rdata_i, bus_rvalid_i,
           bus_rlast_i, bus_bvalid_i,
    input  m_req_ready_o, m_wready_o, m_rdata_o, m_rvalid_o, m_rlast_o,
           m_wdone_o, m_busy_o,
           bus_req_valid_o, bus_addr_o, bus_write_o, bus_len_o,
           bus_wdata_o, bus_wvalid_o, bus_wlast_o
  );
endinterface

// File: rtl/cache_bus_arbiter.sv
// Two-port (ifetch / dcache) arbiter for the cache refill bus: grants whole
// bursts, holds the grant until the read's rlast or the write response.
module cache_bus_arbiter #(
  parameter int LEN_W      = 8,
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  cache_bus_arbiter_if.slave cbus
);
  typedef enum logic [2:0] {IDLE, ADDR, RDATA, WDATA, WRESP} state_t;

  state_t           state;
  logic             gnt;
  logic             last;
  logic             win;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;

  // On a tie, round-robin favours the port that did not win last time.
  always_comb begin
    win = 1'b0;
    case (cbus.m_req_valid_i)
      2'b10:   win = 1'b1;
      2'b11:   win = FIXED_PRIO ? 1'b1 : ~last;
      default: win = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
      len_q <= '0;
    end else begin
      case (state)
        IDLE: if (|cbus.m_req_valid_i) begin
          gnt   <= win;
          last  <= win;
          state <= ADDR;
        end
        ADDR: if (cbus.bus_req_ready_i) begin
          cnt   <= '0;
          len_q <= cbus.m_req_len_i[gnt];
          state <= cbus.m_req_write_i[gnt] ? WDATA : RDATA;
        end
        RDATA: if (cbus.bus_rvalid_i && cbus.bus_rlast_i) state <= IDLE;
        // Counter stops at the last beat so a maximal burst never wraps.
        WDATA: if (cbus.m_wvalid_i[gnt] && cbus.bus_wready_i) begin
          if (cnt == len_q) state <= WRESP;
          else              cnt   <= cnt + 1'b1;
        end
        WRESP: if (cbus.bus_bvalid_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cbus.bus_req_valid_o = (state == ADDR);
  assign cbus.bus_addr_o      = cbus.m_req_addr_i[gnt];
  assign cbus.bus_write_o     = cbus.m_req_write_i[gnt];
  assign cbus.bus_len_o       = cbus.m_req_len_i[gnt];
  assign cbus.bus_wdata_o     = cbus.m_wdata_i[gnt];
  assign cbus.bus_wvalid_o    = (state == WDATA) && cbus.m_wvalid_i[gnt];
  assign cbus.bus_wlast_o     = (state == WDATA) && (cnt == len_q);
  assign cbus.m_rdata_o       = cbus.bus_rdata_i;
  assign cbus.m_rlast_o       = (state == RDATA) && cbus.bus_rvalid_i && cbus.bus_rlast_i;

  // Handshake returns are steered to the granted port only.
  always_comb begin
    cbus.m_req_ready_o = '0;
    cbus.m_rvalid_o    = '0;
    cbus.m_wready_o    = '0;
    cbus.m_wdone_o     = '0;
    case (state)
      ADDR:    cbus.m_req_ready_o[gnt] = cbus.bus_req_ready_i;
      RDATA:   cbus.m_rvalid_o[gnt]    = cbus.bus_rvalid_i;
      WDATA:   cbus.m_wready_o[gnt]    = cbus.bus_wready_i;
      WRESP:   cbus.m_wdone_o[gnt]     = cbus.bus_bvalid_i;
      default: ;
    endcase
  end

  always_comb begin
    cbus.m_busy_o = '0;
    if (state != IDLE) cbus.m_busy_o[~gnt] = 1'b1;
  end
endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench: requester tasks and a downstream responder drive the arbiter;
// a negedge monitor pops hand-computed expected bus events from a scoreboard.
module tb_cache_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_bus_arbiter_if #(.LEN_W(8)) if0 ();
  cache_bus_arbiter_if #(.LEN_W(8)) if1 ();

  cache_bus_arbiter #(.LEN_W(8), .FIXED_PRIO(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .cbus(if0));
  cache_bus_arbiter #(.LEN_W(8), .FIXED_PRIO(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .cbus(if1));

  typedef enum logic [1:0] {EV_ADDR, EV_RB, EV_WB, EV_WD} kind_t;
  typedef struct packed {
    kind_t       kind;
    logic [1:0]  pm;
    logic [31:0] data;
    logic        flag;
    logic [7:0]  len;
  } ev_t;

  ev_t sb[$];
  int  tests = 0;
  int  fails = 0;

  function automatic ev_t mk(kind_t k, logic [1:0] pm, logic [31:0] d, logic f, logic [7:0] l);
    ev_t e;
    e.kind = k; e.pm = pm; e.data = d; e.flag = f; e.len = l;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic obs(input ev_t got);
    ev_t want;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind %0d pm %b data %h flag %b len %0d at %0t",
               got.kind, got.pm, got.data, got.flag, got.len, $time);
    end else begin
      want = sb.pop_front();
      if (got !== want) begin
        fails++;
        $display("FAIL bus_event: got kind %0d pm %b data %h flag %b len %0d, expected kind %0d pm %b data %h flag %b len %0d at %0t",
                 got.kind, got.pm, got.data, got.flag, got.len,
                 want.kind, want.pm, want.data, want.flag, want.len, $time);
      end
    end
  endtask

  // Monitor: every output event of DUT0 must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if0.bus_req_valid_o && if0.bus_req_ready_i)
        obs(mk(EV_ADDR, if0.m_req_ready_o, if0.bus_addr_o, if0.bus_write_o, if0.bus_len_o));
      if (|if0.m_rvalid_o)
        obs(mk(EV_RB, if0.m_rvalid_o, if0.m_rdata_o, if0.m_rlast_o, 8'd0));
      if (if0.bus_wvalid_o && if0.bus_wready_i)
        obs(mk(EV_WB, if0.m_wready_o, if0.bus_wdata_o, if0.bus_wlast_o, 8'd0));
      if (|if0.m_wdone_o)
        obs(mk(EV_WD, if0.m_wdone_o, 32'd0, 1'b0, 8'd0));
    end
  end

  // Downstream responder: read data = start address + beat index.
  int   addr_delay = 0;
  int   b_delay = 1;
  bit   wtoggle = 1'b0;
  int   ad_wait, rd_left, rd_beat, b_cnt;
  logic prev_hs, prev_wl, cap_wr, w_ph;
  logic [31:0] rd_base;
  logic [7:0]  cap_len;

  initial begin
    if0.bus_req_ready_i = 0; if0.bus_wready_i = 0; if0.bus_rdata_i = 0;
    if0.bus_rvalid_i = 0; if0.bus_rlast_i = 0; if0.bus_bvalid_i = 0;
    prev_hs = 0; prev_wl = 0; cap_wr = 0; w_ph = 1; rd_base = 0; cap_len = 0;
    ad_wait = 0; rd_left = 0; rd_beat = 0; b_cnt = 0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        prev_hs = 0; prev_wl = 0; ad_wait = 0; rd_left = 0; b_cnt = 0;
        if0.bus_req_ready_i = 0; if0.bus_wready_i = 0; if0.bus_rvalid_i = 0;
        if0.bus_rlast_i = 0; if0.bus_bvalid_i = 0;
      end else begin
        if (prev_hs) begin
          if (!cap_wr) begin rd_left = int'(cap_len) + 1; rd_beat = 0; end
          w_ph = 1'b1;
        end
        if (prev_wl) b_cnt = 1;
        else if (b_cnt > 0) b_cnt++;
        if0.bus_bvalid_i = (b_cnt > 0) && (b_cnt == b_delay);
        if (if0.bus_bvalid_i) b_cnt = 0;
        if (rd_left > 0) begin
          if0.bus_rvalid_i = 1; if0.bus_rdata_i = rd_base + 32'(rd_beat);
          if0.bus_rlast_i = (rd_left == 1); rd_beat++; rd_left--;
        end else begin
          if0.bus_rvalid_i = 0; if0.bus_rlast_i = 0; if0.bus_rdata_i = 32'hDEAD_0000;
        end
        if0.bus_req_ready_i = 0;
        if (if0.bus_req_valid_o) begin
          if (ad_wait < addr_delay) ad_wait++;
          else begin
            if0.bus_req_ready_i = 1; ad_wait = 0;
            rd_base = if0.bus_addr_o; cap_len = if0.bus_len_o; cap_wr = if0.bus_write_o;
          end
        end
        if0.bus_wready_i = wtoggle ? w_ph : 1'b1;
        w_ph = ~w_ph;
        prev_hs = if0.bus_req_ready_i && if0.bus_req_valid_o;
        prev_wl = if0.bus_wvalid_o && if0.bus_wready_i && if0.bus_wlast_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic exp_txn(input int p, input logic [31:0] addr, input logic wr,
                         input int len, input logic [31:0] wbase);
    logic [1:0] pm;
    pm = 2'b01 << p;
    sb.push_back(mk(EV_ADDR, pm, addr, wr, 8'(len)));
    for (int i = 0; i <= len; i++)
      sb.push_back(mk(wr ? EV_WB : EV_RB, pm, (wr ? wbase : addr) + 32'(i), i == len, 8'd0));
    if (wr) sb.push_back(mk(EV_WD, pm, 32'd0, 1'b0, 8'd0));
  endtask

  task automatic raise(input int p, input logic [31:0] addr, input logic wr, input int len);
    if0.m_req_addr_i[p] = addr; if0.m_req_write_i[p] = wr;
    if0.m_req_len_i[p] = 8'(len); if0.m_req_valid_i[p] = 1'b1;
  endtask

  task automatic finish(input int p, input logic wr, input int len, input logic [31:0] wbase);
    logic acc;
    int   n;
    n = 0; acc = 0;
    do begin
      @(negedge clk); acc = if0.m_req_ready_o[p]; tick(); n++;
    end while (!acc && n < 100);
    if0.m_req_valid_i[p] = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL req_handshake_timeout: port %0d got no ready, expected ready within 100 cycles", p);
    end else if (wr) begin
      for (int b = 0; b <= len; b++) begin
        if0.m_wdata_i[p] = wbase + 32'(b); if0.m_wvalid_i[p] = 1'b1;
        n = 0;
        do begin
          @(negedge clk); acc = if0.m_wready_o[p]; tick(); n++;
        end while (!acc && n < 100);
        if (!acc) begin
          tests++; fails++;
          $display("FAIL wbeat_timeout: port %0d beat %0d got no wready, expected within 100 cycles", p, b);
          break;
        end
      end
      if0.m_wvalid_i[p] = 1'b0;
    end
  endtask

  task automatic request(input int p, input logic [31:0] addr, input logic wr,
                         input int len, input logic [31:0] wbase);
    raise(p, addr, wr, len);
    finish(p, wr, len, wbase);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((if0.m_busy_o != 2'b00 || sb.size() != 0) && n < 300) begin tick(); n++; end
    if (n >= 300) begin
      tests++; fails++;
      $display("FAIL idle_timeout: busy %b pending %0d, expected idle and drained", if0.m_busy_o, sb.size());
    end
    tick();
  endtask

  function automatic logic [31:0] ctl_vec();
    return 32'({if0.bus_req_valid_o, if0.m_req_ready_o, if0.m_rvalid_o, if0.m_rlast_o,
                if0.m_wready_o, if0.m_wdone_o, if0.m_busy_o, if0.bus_wvalid_o, if0.bus_wlast_o});
  endfunction

  // DUT1 (fixed priority) sees a permanent tie and a bus that completes every read at once.
  initial begin
    if1.m_req_valid_i = 2'b11; if1.m_req_addr_i = '0; if1.m_req_write_i = 2'b00;
    if1.m_req_len_i = '0; if1.m_wdata_i = '0; if1.m_wvalid_i = 2'b00;
    if1.bus_req_ready_i = 1; if1.bus_wready_i = 0; if1.bus_rdata_i = 0;
    if1.bus_rvalid_i = 1; if1.bus_rlast_i = 1; if1.bus_bvalid_i = 0;
  end

  initial begin
    int g;
    int e;
    logic [31:0] a0, a1;
    if0.m_req_valid_i = 0; if0.m_req_addr_i = '0; if0.m_req_write_i = 0;
    if0.m_req_len_i = '0; if0.m_wdata_i = '0; if0.m_wvalid_i = 0;

    repeat (3) tick();
    chk("reset_outputs", ctl_vec(), 32'd0);
    chk("reset_outputs_prio", 32'({if1.bus_req_valid_o, if1.m_req_ready_o, if1.m_busy_o}), 32'd0);
    rst_n = 1'b1;

    // Fixed priority: port 1 wins every tie.
    g = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if1.bus_req_valid_o) begin
        chk("prio1_grant", 32'(if1.m_req_ready_o), 32'h2);
        g++;
      end
    end
    chk("prio1_grant_count", 32'(g), 32'd4);
    tick();

    // Round-robin ties alternate 0,1,0,1 from reset; the loser withdraws.
    for (int i = 0; i < 4; i++) begin
      e = i % 2;
      a0 = 32'h1000_0100 + 32'(i);
      a1 = 32'h1000_0200 + 32'(i);
      exp_txn(e, (e == 1) ? a1 : a0, 1'b0, 0, 32'd0);
      raise(0, a0, 1'b0, 0);
      raise(1, a1, 1'b0, 0);
      tick();
      if0.m_req_valid_i[1-e] = 1'b0;
      finish(e, 1'b0, 0, 32'd0);
      wait_idle();
    end

    // Single 4-beat read on port 0.
    exp_txn(0, 32'h1C00_0000, 1'b0, 3, 32'd0);
    raise(0, 32'h1C00_0000, 1'b0, 3);
    chk("addr_latency_t0", 32'(if0.bus_req_valid_o), 32'd0);
    fork
      finish(0, 1'b0, 3, 32'd0);
      begin
        tick();
        chk("addr_latency_t1", 32'(if0.bus_req_valid_o), 32'd1);
        chk("busy_rd0", 32'(if0.m_busy_o), 32'h2);
        tick(); tick();
        chk("busy_rd0_beats", 32'(if0.m_busy_o), 32'h2);
      end
    join
    wait_idle();
    chk("busy_after_rd0", 32'(if0.m_busy_o), 32'd0);

    // Port 1 write burst A,B,C with toggling wready and a late response.
    wtoggle = 1'b1; b_delay = 5;
    exp_txn(1, 32'h2000_0040, 1'b1, 2, 32'hA);
    request(1, 32'h2000_0040, 1'b1, 2, 32'hA);
    wait_idle();
    wtoggle = 1'b0; b_delay = 1;

    // Port 1 waits behind port 0's 8-beat read, then wins the next arbitration.
    exp_txn(0, 32'h3000_0000, 1'b0, 7, 32'd0);
    exp_txn(1, 32'h4000_0000, 1'b0, 1, 32'd0);
    fork
      request(0, 32'h3000_0000, 1'b0, 7, 32'd0);
      begin
        repeat (4) tick();
        raise(1, 32'h4000_0000, 1'b0, 1);
        for (int i = 0; i < 6; i++) begin
          chk("blocked_p1", 32'({if0.m_busy_o, if0.m_req_ready_o[1]}), 32'h4);
          tick();
        end
        tick();
        chk("p1_granted_next", 32'({if0.m_busy_o, if0.bus_req_valid_o}), 32'h3);
        finish(1, 1'b0, 1, 32'd0);
      end
    join
    wait_idle();

    // Reset during the second beat of a len 7 read.
    sb.push_back(mk(EV_ADDR, 2'b01, 32'h5000_0000, 1'b0, 8'd7));
    sb.push_back(mk(EV_RB, 2'b01, 32'h5000_0000, 1'b0, 8'd0));
    request(0, 32'h5000_0000, 1'b0, 7, 32'd0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("midburst_reset_outputs", ctl_vec(), 32'd0);
    chk("midburst_reset_drained", 32'(sb.size()), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_txn(0, 32'h6000_0000, 1'b0, 0, 32'd0);
    request(0, 32'h6000_0000, 1'b0, 0, 32'd0);
    wait_idle();

    // Single-beat write with a slow address accept.
    addr_delay = 3;
    exp_txn(0, 32'h7000_0000, 1'b1, 0, 32'h55);
    request(0, 32'h7000_0000, 1'b1, 0, 32'h55);
    wait_idle();
    addr_delay = 0;

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
